// File: rtl/fpga_receiver_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fpga_receiver_fifo
//  Description : Serial FPGA-to-FPGA frame receiver with send/finish/
//                acknowledge handshake, optional even parity and a DEPTH-entry
//                show-ahead FIFO drained through a received/processed handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpga_receiver_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int PARITY = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         data,
  input  logic                         send,
  input  logic                         finish,
  output logic                         acknowledge,
  output logic [WIDTH-1:0]             data_out,
  output logic                         received,
  input  logic                         processed,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         error
);

  localparam int c_FRAME = WIDTH + PARITY;
  localparam int c_CW    = $clog2(c_FRAME + 1);
  localparam int c_AW    = $clog2(DEPTH);
  localparam int c_NW    = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  // A one-bit frame is complete as soon as its first bit is sampled.
  localparam state_t c_AFTER_FIRST = (c_FRAME == 1) ? S_WAIT : S_SHIFT;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [c_FRAME-1:0]     r_shift;
  logic [c_CW-1:0]        r_bits;
  logic                   r_ack;
  logic                   r_error;
  logic [WIDTH-1:0]       r_mem [DEPTH];
  logic [c_AW-1:0]        r_wr_ptr;
  logic [c_AW-1:0]        r_rd_ptr;
  logic [c_NW-1:0]        r_count;
  logic                   r_full;
  logic                   r_received;

  logic                   w_load_first;
  logic                   w_shift_en;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_err_det;
  logic                   w_parity_bad;
  logic                   w_has_space;
  logic [WIDTH-1:0]       w_word;
  logic [c_NW-1:0]        w_count_next;

  // Data bits arrive first (MSB first), the parity bit, if any, sits in the LSB.
  assign w_word = r_shift[c_FRAME-1 -: WIDTH];

  generate
    if (PARITY != 0) begin : g_parity
      assign w_parity_bad = ^r_shift;
    end else begin : g_no_parity
      assign w_parity_bad = 1'b0;
    end
  endgenerate

  // A pop is only real when there is something to pop; popping frees a slot
  // for a simultaneous push even when the buffer is full.
  assign w_pop       = processed & r_received;
  assign w_has_space = ~r_full | w_pop;

  // Next-state and control decode for the frame handshake.
  always_comb begin
    w_next_state = r_state;
    w_load_first = 1'b0;
    w_shift_en   = 1'b0;
    w_push       = 1'b0;
    w_err_det    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (send) begin
          w_load_first = 1'b1;
          w_next_state = c_AFTER_FIRST;
        end
      end
      S_SHIFT: begin
        if (send) begin
          w_shift_en = 1'b1;
          if (r_bits == c_CW'(c_FRAME - 1)) begin
            w_next_state = S_WAIT;
          end
        end else begin
          w_err_det    = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_WAIT: begin
        if (finish) begin
          if (w_parity_bad) begin
            w_err_det    = 1'b1;
            w_next_state = S_ACK;
          end else if (w_has_space) begin
            w_push       = 1'b1;
            w_next_state = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (!finish) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register with registered acknowledge and error pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_ack   <= (w_next_state == S_ACK);
      r_error <= w_err_det;
    end
  end

  // Shift register and bit counter collecting the serial frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_shift <= '0;
      r_bits  <= '0;
    end else if (w_load_first) begin
      r_shift <= c_FRAME'(data);
      r_bits  <= c_CW'(1);
    end else if (w_shift_en) begin
      r_shift <= (r_shift << 1) | c_FRAME'(data);
      r_bits  <= r_bits + c_CW'(1);
    end
  end

  // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + c_NW'(1);
      2'b01:   w_count_next = r_count - c_NW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // FIFO storage, wrapping pointers and registered status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_received <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_word;
        r_wr_ptr        <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      r_count    <= w_count_next;
      r_full     <= (w_count_next == c_NW'(DEPTH));
      r_received <= (w_count_next != '0);
    end
  end

  assign acknowledge = r_ack;
  assign error       = r_error;
  assign received    = r_received;
  assign full        = r_full;
  assign count       = r_count;
  assign data_out    = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_fpga_receiver_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpga_receiver_fifo
//  Description : Self-checking bench for fpga_receiver_fifo. Three instances:
//                8-bit no parity (queue model + per-cycle compare), 8-bit
//                even parity, and 1-bit no parity (directed checks).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpga_receiver_fifo;

  logic clock;
  logic reset;
  logic d, s, f, p;
  int   sel;

  int checks;
  int failures;

  // per-instance inputs, muxed from one driver set
  logic d0, s0, f0, p0, d1, s1, f1, p1, d2, s2, f2, p2;
  assign d0 = (sel == 0) ? d : 1'b0;
  assign s0 = (sel == 0) ? s : 1'b0;
  assign f0 = (sel == 0) ? f : 1'b0;
  assign p0 = (sel == 0) ? p : 1'b0;
  assign d1 = (sel == 1) ? d : 1'b0;
  assign s1 = (sel == 1) ? s : 1'b0;
  assign f1 = (sel == 1) ? f : 1'b0;
  assign p1 = (sel == 1) ? p : 1'b0;
  assign d2 = (sel == 2) ? d : 1'b0;
  assign s2 = (sel == 2) ? s : 1'b0;
  assign f2 = (sel == 2) ? f : 1'b0;
  assign p2 = (sel == 2) ? p : 1'b0;

  logic       ack0, rcv0, full0, err0;
  logic [7:0] dout0;
  logic [2:0] cnt0;
  logic       ack1, rcv1, full1, err1;
  logic [7:0] dout1;
  logic [2:0] cnt1;
  logic       ack2, rcv2, full2, err2;
  logic [0:0] dout2;
  logic [2:0] cnt2;

  fpga_receiver_fifo #(.WIDTH(8), .DEPTH(4), .PARITY(0)) u_dut0 (
    .clock(clock), .reset(reset), .data(d0), .send(s0), .finish(f0),
    .acknowledge(ack0), .data_out(dout0), .received(rcv0), .processed(p0),
    .full(full0), .count(cnt0), .error(err0)
  );

  fpga_receiver_fifo #(.WIDTH(8), .DEPTH(4), .PARITY(1)) u_dut1 (
    .clock(clock), .reset(reset), .data(d1), .send(s1), .finish(f1),
    .acknowledge(ack1), .data_out(dout1), .received(rcv1), .processed(p1),
    .full(full1), .count(cnt1), .error(err1)
  );

  fpga_receiver_fifo #(.WIDTH(1), .DEPTH(4), .PARITY(0)) u_dut2 (
    .clock(clock), .reset(reset), .data(d2), .send(s2), .finish(f2),
    .acknowledge(ack2), .data_out(dout2), .received(rcv2), .processed(p2),
    .full(full2), .count(cnt2), .error(err2)
  );

  logic sel_ack;
  assign sel_ack = (sel == 0) ? ack0 : (sel == 1) ? ack1 : ack2;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model of instance 0 -------------------------
  bit         m_valid;
  bit         m_ack;
  bit         m_err;
  bit         m_bits[$];
  logic [7:0] m_q[$];

  always @(posedge clock) begin
    bit         pop;
    bit         push;
    bit         err_n;
    logic [7:0] w;
    m_valid = 1'b1;
    if (reset) begin
      m_bits.delete();
      m_q.delete();
      m_ack = 1'b0;
      m_err = 1'b0;
    end else begin
      err_n = 1'b0;
      push  = 1'b0;
      w     = 8'h00;
      pop   = p0 && (m_q.size() > 0);
      if (m_ack) begin
        if (!f0) m_ack = 1'b0;
      end else if (m_bits.size() == 8) begin
        if (f0 && (m_q.size() < 4 || pop)) begin
          for (int i = 0; i < 8; i++) w = {w[6:0], m_bits[i]};
          push  = 1'b1;
          m_ack = 1'b1;
          m_bits.delete();
        end
      end else if (s0) begin
        m_bits.push_back(d0);
      end else if (m_bits.size() != 0) begin
        err_n = 1'b1;
        m_bits.delete();
      end
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(w);
      m_err = err_n;
    end
  end

  // per-cycle compare of instance 0 against the model
  always @(negedge clock) begin
    if (m_valid) begin
      chk("cyc_ack",      int'(ack0),  int'(m_ack));
      chk("cyc_error",    int'(err0),  int'(m_err));
      chk("cyc_received", int'(rcv0),  int'(m_q.size() != 0));
      chk("cyc_count",    int'(cnt0),  m_q.size());
      chk("cyc_full",     int'(full0), int'(m_q.size() == 4));
      if (m_q.size() != 0) chk("cyc_data_out", int'(dout0), int'(m_q[0]));
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      d = v[i];
      s = 1'b1;
      @(negedge clock);
    end
    s = 1'b0;
    d = 1'b0;
  endtask

  task automatic finish_frame(input int budget);
    int k;
    k = 0;
    f = 1'b1;
    do begin
      @(negedge clock);
      k++;
    end while (!sel_ack && k < budget);
    if (!sel_ack) begin
      checks++;
      failures++;
      $display("FAIL handshake_timeout ack=0 required=1");
    end
    f = 1'b0;
    @(negedge clock);
  endtask

  task automatic pop_one();
    p = 1'b1;
    @(negedge clock);
    p = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; sel = 0;
    d = 1'b0; s = 1'b0; f = 1'b0; p = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_ack",      int'(ack0),  0);
    chk("rst_received", int'(rcv0),  0);
    chk("rst_count",    int'(cnt0),  0);
    chk("rst_full",     int'(full0), 0);
    chk("rst_error",    int'(err0),  0);
    chk("rst_data_out", int'(dout0), 0);
    reset = 1'b0;
    @(negedge clock);

    // single word
    send_bits(16'h00A5, 8);
    f = 1'b1;
    @(negedge clock);
    chk("single_ack",  int'(ack0),  1);
    chk("single_rcv",  int'(rcv0),  1);
    chk("single_data", int'(dout0), 8'hA5);
    chk("single_cnt",  int'(cnt0),  1);
    f = 1'b0;
    @(negedge clock);
    chk("single_ack_low", int'(ack0), 0);
    pop_one();
    chk("single_pop_rcv", int'(rcv0), 0);
    chk("single_pop_cnt", int'(cnt0), 0);

    // processed on empty FIFO
    pop_one();
    chk("empty_pop_cnt", int'(cnt0), 0);

    // fill, stall, push+pop while full
    for (int v = 1; v <= 4; v++) begin
      send_bits(16'(v), 8);
      finish_frame(10);
    end
    chk("fill_full", int'(full0), 1);
    chk("fill_cnt",  int'(cnt0),  4);
    send_bits(16'h0005, 8);
    f = 1'b1;
    repeat (3) @(negedge clock);
    chk("stall_ack", int'(ack0), 0);
    p = 1'b1;
    @(negedge clock);
    p = 1'b0;
    chk("stall_release_ack", int'(ack0),  1);
    chk("stall_release_cnt", int'(cnt0),  4);
    chk("stall_head",        int'(dout0), 8'h02);
    f = 1'b0;
    @(negedge clock);
    for (int v = 2; v <= 5; v++) begin
      chk("drain_order", int'(dout0), v);
      pop_one();
    end
    chk("drain_cnt", int'(cnt0), 0);

    // short frame then a good frame
    send_bits(16'h0005, 3);
    @(negedge clock);
    chk("short_err", int'(err0), 1);
    @(negedge clock);
    chk("short_err_gone", int'(err0), 0);
    chk("short_no_push",  int'(cnt0), 0);
    send_bits(16'h003C, 8);
    finish_frame(10);
    chk("after_short_data", int'(dout0), 8'h3C);
    chk("after_short_cnt",  int'(cnt0),  1);

    // reset while in ACK with two words stored
    send_bits(16'h0077, 8);
    f = 1'b1;
    @(negedge clock);
    chk("pre_reset_ack", int'(ack0), 1);
    chk("pre_reset_cnt", int'(cnt0), 2);
    reset = 1'b1;
    @(negedge clock);
    chk("reset_ack", int'(ack0), 0);
    chk("reset_rcv", int'(rcv0), 0);
    chk("reset_cnt", int'(cnt0), 0);
    reset = 1'b0;
    f = 1'b0;
    @(negedge clock);

    // parity instance
    sel = 1;
    send_bits(16'h001E, 9);
    finish_frame(10);
    chk("par_good_cnt",  int'(cnt1),  1);
    chk("par_good_data", int'(dout1), 8'h0F);
    send_bits(16'h001F, 9);
    f = 1'b1;
    @(negedge clock);
    chk("par_bad_err", int'(err1), 1);
    chk("par_bad_ack", int'(ack1), 1);
    chk("par_bad_cnt", int'(cnt1), 1);
    f = 1'b0;
    @(negedge clock);
    chk("par_err_gone", int'(err1),  0);
    chk("par_full",     int'(full1), 0);

    // one-bit instance
    sel = 2;
    send_bits(16'h0001, 1);
    finish_frame(10);
    chk("w1_cnt1",  int'(cnt2),  1);
    chk("w1_data1", int'(dout2), 1);
    send_bits(16'h0000, 1);
    finish_frame(10);
    chk("w1_cnt2",  int'(cnt2),  2);
    chk("w1_head",  int'(dout2), 1);
    pop_one();
    chk("w1_data2", int'(dout2), 0);
    chk("w1_cnt3",  int'(cnt2),  1);
    chk("w1_full",  int'(full2), 0);
    chk("w1_rcv",   int'(rcv2),  1);

    sel = 0;
    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
